dac_spi_receiver: RTL

- SPI peripheral-side receiver for the 16-bit DAC word stream that the display controller drives on its x/y galvo channels (sclk, mosi, active-low cs).
- Oversamples the SPI lines on the system clock, shifts in one frame per cs-low window, and decodes it into channel/gain/shutdown/12-bit value.
- Used as a synthesizable loopback monitor and as the bench-side checker for the display controller's DAC outputs.
- One instance per axis.

---
 rtl/dac_spi_receiver.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dac_spi_receiver.sv
// dac_spi_receiver
//   Peripheral-side receiver for one axis of the galvo DAC word stream.
//   The SPI lines are oversampled on clock_in. Each cs-low window carries
//   one frame. A frame of exactly WORD_BITS bits is decoded into
//   channel/gain/shutdown/value fields. A frame of any other length raises
//   an error pulse.
//
// Ports
//   clock_in        system clock; all state changes on its rising edge
//   reset_in        asynchronous, active-low reset
//   sclk_in         SPI clock, asynchronous; data is taken on its rising edge
//   mosi_in         SPI data, MSB first
//   cs_in           active-low chip select; one frame per low window
//   valid_out       one-cycle pulse: a well-formed frame was decoded
//   error_out       one-cycle pulse: the frame closed with a wrong bit count
//   channel_out     frame bit 15 (0 = A, 1 = B)
//   gain_n_out      frame bit 13 (1 = 1x gain, 0 = 2x gain)
//   shdn_n_out      frame bit 12 (0 = output shut down)
//   value_out       frame bits DATA_BITS-1:0
//   frame_count_out count of good frames; wraps from 0xFFFF to 0x0000
//
// Handshake: valid_out and error_out are single-cycle strobes with no ready.
// The decoded fields change only in the cycle valid_out is high, and they
// hold between frames.
module dac_spi_receiver #(
   parameter int WORD_BITS   = 16,
   parameter int DATA_BITS   = 12,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clock_in,
   input  logic                 reset_in,
   input  logic                 sclk_in,
   input  logic                 mosi_in,
   input  logic                 cs_in,
   output logic                 valid_out,
   output logic                 error_out,
   output logic                 channel_out,
   output logic                 gain_n_out,
   output logic                 shdn_n_out,
   output logic [DATA_BITS-1:0] value_out,
   output logic [15:0]          frame_count_out
);

   localparam int CNT_W = $clog2(WORD_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_BITS + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

   // ---------------- synchronizers, history and edge strobes ----------------
   logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
   logic                   sclk_hist, cs_hist;
   // settle fills with ones after reset. Edges are masked until the chains
   // hold real input levels. This stops a cs already low at release from
   // looking like a falling edge.
   logic [SYNC_STAGES:0]   settle;
   logic                   sclk_s, cs_s, mosi_s, edges_ok;
   logic                   sclk_rise_q, cs_fall_q, cs_rise_q, mosi_q;

   assign sclk_s   = sclk_sync[SYNC_STAGES-1];
   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign edges_ok = settle[SYNC_STAGES];

   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         sclk_sync   <= '0;
         mosi_sync   <= '0;
         cs_sync     <= '1;
         sclk_hist   <= 1'b0;
         cs_hist     <= 1'b1;
         settle      <= '0;
         sclk_rise_q <= 1'b0;
         cs_fall_q   <= 1'b0;
         cs_rise_q   <= 1'b0;
         mosi_q      <= 1'b0;
      end else begin
         sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
         mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
         cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs_in};
         sclk_hist   <= sclk_s;
         cs_hist     <= cs_s;
         settle      <= {settle[SYNC_STAGES-1:0], 1'b1};
         sclk_rise_q <= edges_ok &  sclk_s & ~sclk_hist;
         cs_fall_q   <= edges_ok & ~cs_s   &  cs_hist;
         cs_rise_q   <= edges_ok &  cs_s   & ~cs_hist;
         // mosi is delayed by the same amount as the sclk strobe.
         mosi_q      <= mosi_s;
      end
   end

   // ---------------- FSM ----------------
   state_t state_q, state_d;
   logic   fall_pending_q;
   logic   start_frame, shift_en, check_en, latch_fall;

   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cs_fall_q || fall_pending_q) state_d = SHIFT;
         SHIFT:   if (cs_rise_q)                   state_d = CHECK;
         CHECK:                                    state_d = IDLE;
         default:                                  state_d = IDLE;
      endcase
   end

   always_comb begin
      start_frame = 1'b0;
      shift_en    = 1'b0;
      check_en    = 1'b0;
      latch_fall  = 1'b0;
      case (state_q)
         IDLE:  start_frame = cs_fall_q || fall_pending_q;
         // An sclk rise that coincides with cs closing is not part of the frame.
         SHIFT: shift_en    = sclk_rise_q && !cs_rise_q;
         CHECK: begin
            check_en   = 1'b1;
            latch_fall = cs_fall_q;
         end
         default: ;
      endcase
   end

   // ---------------- datapath ----------------
   logic [WORD_BITS-1:0] shift_q;
   logic [CNT_W-1:0]     count_q;
   logic                 frame_ok;
   logic                 reserved_bit_unused;

   assign frame_ok            = (count_q == CNT_FULL);
   assign reserved_bit_unused = shift_q[WORD_BITS-2];

   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         shift_q        <= '0;
         count_q        <= '0;
         fall_pending_q <= 1'b0;
      end else begin
         if (start_frame) begin
            shift_q <= '0;
            count_q <= '0;
         end else if (shift_en) begin
            shift_q <= {shift_q[WORD_BITS-2:0], mosi_q};
            if (count_q != CNT_SAT) count_q <= count_q + 1'b1;
         end
         // A cs fall during CHECK would otherwise be lost.
         if (latch_fall)       fall_pending_q <= 1'b1;
         else if (start_frame) fall_pending_q <= 1'b0;
      end
   end

   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         valid_out       <= 1'b0;
         error_out       <= 1'b0;
         channel_out     <= 1'b0;
         gain_n_out      <= 1'b0;
         shdn_n_out      <= 1'b1;
         value_out       <= '0;
         frame_count_out <= '0;
      end else begin
         valid_out <= check_en &&  frame_ok;
         error_out <= check_en && !frame_ok;
         if (check_en && frame_ok) begin
            channel_out     <= shift_q[WORD_BITS-1];
            gain_n_out      <= shift_q[WORD_BITS-3];
            shdn_n_out      <= shift_q[WORD_BITS-4];
            value_out       <= shift_q[DATA_BITS-1:0];
            frame_count_out <= frame_count_out + 16'd1;
         end
      end
   end

endmodule
